// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with two prioritised write ports
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int REG_READ = 0
) (
   input  logic                    clock,
   input  logic                    ctrl_reset,
   input  logic                    ctrl_writeEnA,
   input  logic [ADDR_W-1:0]       ctrl_writeRegA,
   input  logic [DATA_W-1:0]       data_writeRegA,
   input  logic                    ctrl_writeEnB,
   input  logic [ADDR_W-1:0]       ctrl_writeRegB,
   input  logic [DATA_W-1:0]       data_writeRegB,
   input  logic [NREAD*ADDR_W-1:0] ctrl_readReg,
   output logic [NREAD*DATA_W-1:0] data_readReg
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];

   // Effective write strobes: a write to register 0 is dropped when it is hardwired.
   logic wr_a;
   logic wr_b;

   assign wr_a = ctrl_writeEnA && !((ZERO_REG != 0) && (ctrl_writeRegA == '0));
   assign wr_b = ctrl_writeEnB && !((ZERO_REG != 0) && (ctrl_writeRegB == '0));

   // Storage update: reset wins over writes; port B is applied last so it wins a collision.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (wr_a) begin
            regs[ctrl_writeRegA] <= data_writeRegA;
         end
         if (wr_b) begin
            regs[ctrl_writeRegB] <= data_writeRegB;
         end
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;

      assign addr = ctrl_readReg[p*ADDR_W +: ADDR_W];

      // Read select: stored value, overridden by same-cycle write data (B over A), zero for reg 0.
      always_comb begin
         val = regs[addr];
         if ((BYPASS != 0) && !ctrl_reset) begin
            if (ctrl_writeEnA && (ctrl_writeRegA == addr)) begin
               val = data_writeRegA;
            end
            if (ctrl_writeEnB && (ctrl_writeRegB == addr)) begin
               val = data_writeRegB;
            end
         end
         if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
         end
      end

      if (REG_READ != 0) begin : g_reg
         logic [DATA_W-1:0] q;

         // Registered read: capture the selected value every edge, cleared by reset.
         always_ff @(posedge clock) begin
            if (ctrl_reset) begin
               q <= '0;
            end else begin
               q <= val;
            end
         end

         assign data_readReg[p*DATA_W +: DATA_W] = q;
      end else begin : g_comb
         assign data_readReg[p*DATA_W +: DATA_W] = val;
      end
   end

endmodule
